alignment_engine: RTL and testbench
===================================

// Module: alignment_engine
// PURPOSE
//  Time-multiplexed sequence-alignment scorer and parametrised successor of the fully unrolled NxM grid.
//  Computes one DP cell per clock over a single row buffer, so area scales with MAX_M rather than N*M.
//  Sequence lengths, match/mismatch/gap scores and mode (global Needleman-Wunsch or local
//  Smith-Waterman) are set at run time. Symbols load over a write port; the final score leaves on a valid/ready port.
// PARAMETERS
//  MAX_N    64  max length of sequence a (rows)
//  MAX_M    64  max length of sequence b (columns)
//  SYM_W    2   symbol width in bits (2 = DNA)
//  SCORE_W  16  signed score/accumulator width
//  LEN_W    $clog2(MAX_N>MAX_M?MAX_N+1:MAX_M+1)  length/index width
// PORTS
//  clk               in   1        clock, rising edge
//  reset             in   1        asynchronous, active-high
//  seq_valid         in   1        symbol write request
//  seq_ready         out  1        1 only in IDLE; a write occurs when seq_valid&seq_ready
//  seq_sel           in   1        0 = sequence a, 1 = sequence b
//  seq_addr          in   LEN_W    0-based symbol index
//  seq_sym           in   SYM_W    symbol value
//  n_len, m_len      in   LEN_W    lengths of a and b, sampled on start acceptance
//  match_score       in   SCORE_W  signed; added on diagonal step when a[i]==b[j]
//  mismatch_penalty  in   SCORE_W  signed; added on diagonal step when a[i]!=b[j]
//  gap_penalty       in   SCORE_W  signed; added on vertical/horizontal steps
//  mode              in   1        0 = global, 1 = local
//  start             in   1        begin run (honoured only in IDLE)
//  busy              out  1        1 in INIT/COMPUTE/OUT
//  cfg_err           out  1        1-cycle pulse: start rejected
//  sol_valid         out  1        solution valid, held until sol_ready
//  sol_ready         in   1        consumer accepts solution
//  solution          out  SCORE_W  signed final score
// BEHAVIOUR
//  Reset: state=IDLE; busy, cfg_err and sol_valid = 0; solution = 0. Sequence memories are retained,
//   but their contents after reset are not guaranteed.
//  FSM IDLE -> INIT -> COMPUTE -> OUT -> IDLE.
//  IDLE: on start=1, if n_len or m_len is 0, or n_len>MAX_N, or m_len>MAX_M: pulse cfg_err and stay in IDLE.
//   Otherwise latch lengths, scores and mode, then go to INIT. Writes with addr >= MAX are dropped.
//  INIT: m_len+1 cycles, writing row[j] = (mode ? 0 : j*gap_penalty) for j=0..m_len.
//  COMPUTE: exactly n_len*m_len cycles, row-major order (i=1..n, j=1..m), one cell per cycle:
//   H = max(diag + s(a[i-1],b[j-1]), up + gap, left + gap), where s = match or mismatch.
//   up = row[j]; diag = row[j-1] held from the previous cycle; left = H of the previous cell.
//   At j=1: diag = (i-1)*gap and left = i*gap in global mode; both are 0 in local mode.
//   Local mode: H = max(H,0); track best = max of all H (initialised to 0).
//   All adds saturate to the signed SCORE_W range, so there is no wrap-around.
//  OUT: solution = global ? H[n][m] : best; sol_valid=1. State and solution hold while sol_ready=0.
//   On sol_valid&sol_ready, return to IDLE next edge and clear sol_valid.
//  Latency: counting the start-sampling edge as edge 1, sol_valid is first high after edge m+2+n*m.
//  start while busy is ignored, with no cfg_err. Config input changes after acceptance have no effect.
//  seq_ready=0 outside IDLE, so sequences cannot change mid-run.
//  reset mid-run: immediate return to IDLE with all outputs at reset values; no stale sol_valid afterwards.
//  sol_valid and sol_ready in the same cycle as a new start: the start is ignored (state is OUT, not IDLE).
// TESTING
//  1 global, match=1 mismatch=0 gap=0, a=b=ACGT (n=m=4) -> solution=4.
//  2 global, match=2 mismatch=-1 gap=-2, a=AAAA, b=AAA -> solution=4.
//  3 local, match=1 mismatch=-1 gap=-1, a=TTACGTT, b=GGACGGG -> solution=3.
//  4 n=3 m=5: sol_valid first high after edge 22; hold sol_ready=0 for 10 cycles -> solution stable,
//    sol_valid=1, start ignored; pulse sol_ready -> IDLE on the next edge.
//  5 start with n_len=0, then with m_len=MAX_M+1 -> one cfg_err pulse each, busy stays 0, no sol_valid.
//  6 assert reset mid-COMPUTE -> busy=sol_valid=0 and solution=0 at once; reload and rerun test 2 -> solution=4.
//  Saturation: global, gap=-32768, n=m=2, all mismatch -> solution=-32768.
//  Randomised runs are checked against a software DP model.

Source files
------------

// File: rtl/alignment_engine.sv
// rtl/alignment_engine.sv - time-multiplexed global/local sequence alignment scorer
// One DP cell per clock over a single row buffer; result leaves on a valid/ready port.
module alignment_engine #(
  parameter int MAX_N   = 64,
  parameter int MAX_M   = 64,
  parameter int SYM_W   = 2,
  parameter int SCORE_W = 16,
  parameter int LEN_W   = $clog2(MAX_N > MAX_M ? MAX_N + 1 : MAX_M + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      seq_valid,
  output logic                      seq_ready,
  input  logic                      seq_sel,
  input  logic [LEN_W-1:0]          seq_addr,
  input  logic [SYM_W-1:0]          seq_sym,
  input  logic [LEN_W-1:0]          n_len,
  input  logic [LEN_W-1:0]          m_len,
  input  logic signed [SCORE_W-1:0] match_score,
  input  logic signed [SCORE_W-1:0] mismatch_penalty,
  input  logic signed [SCORE_W-1:0] gap_penalty,
  input  logic                      mode,
  input  logic                      start,
  output logic                      busy,
  output logic                      cfg_err,
  output logic                      sol_valid,
  input  logic                      sol_ready,
  output logic signed [SCORE_W-1:0] solution
);
  localparam int AW_A = $clog2(MAX_N);
  localparam int AW_B = $clog2(MAX_M);
  localparam int RW   = $clog2(MAX_M + 1);
  localparam logic [LEN_W-1:0] MAX_N_L = LEN_W'(MAX_N);
  localparam logic [LEN_W-1:0] MAX_M_L = LEN_W'(MAX_M);
  localparam logic signed [SCORE_W-1:0] S_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic signed [SCORE_W-1:0] S_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, INIT, COMPUTE, OUT} state_t;
  state_t state, state_nxt;

  function automatic logic signed [SCORE_W-1:0] sat_add(input logic signed [SCORE_W-1:0] x,
                                                        input logic signed [SCORE_W-1:0] y);
    logic [SCORE_W:0] s;
    s = {x[SCORE_W-1], x} + {y[SCORE_W-1], y};
    if (s[SCORE_W] != s[SCORE_W-1]) sat_add = s[SCORE_W] ? S_MIN : S_MAX;
    else sat_add = s[SCORE_W-1:0];
  endfunction

  function automatic logic signed [SCORE_W-1:0] max2(input logic signed [SCORE_W-1:0] x,
                                                     input logic signed [SCORE_W-1:0] y);
    max2 = (x > y) ? x : y;
  endfunction

  logic [SYM_W-1:0]          mem_a [0:MAX_N-1];
  logic [SYM_W-1:0]          mem_b [0:MAX_M-1];
  logic signed [SCORE_W-1:0] row   [0:MAX_M];

  logic [LEN_W-1:0]          n_r, m_r, i_cnt, j_cnt;
  logic signed [SCORE_W-1:0] match_r, mis_r, gap_r;
  logic                      mode_r;
  logic signed [SCORE_W-1:0] init_val, edge_r, diag_r, left_r, best_r;

  logic                      cfg_bad, last_cell, first_col, row_we;
  logic [SYM_W-1:0]          sym_a, sym_b;
  logic signed [SCORE_W-1:0] up, diag, left, sub, h_raw, h, row_wdata;

  assign cfg_bad = (n_len == '0) || (m_len == '0) || (n_len > MAX_N_L) || (m_len > MAX_M_L);
  assign last_cell = (i_cnt == n_r) && (j_cnt == m_r);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    seq_ready = 1'b0;
    sol_valid = 1'b0;
    case (state)
      IDLE: begin
        seq_ready = 1'b1;
        if (start && !cfg_bad) state_nxt = INIT;
      end
      INIT: begin
        busy = 1'b1;
        if (j_cnt == m_r) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_cell) state_nxt = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        sol_valid = 1'b1;
        if (sol_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Column 0 is never stored: its diag/left come from edge_r, which tracks (i-1)*gap.
  always_comb begin
    sym_a     = mem_a[AW_A'(i_cnt - 1'b1)];
    sym_b     = mem_b[AW_B'(j_cnt - 1'b1)];
    up        = row[j_cnt[RW-1:0]];
    first_col = (j_cnt == LEN_W'(1));
    diag      = first_col ? (mode_r ? '0 : edge_r) : diag_r;
    left      = first_col ? (mode_r ? '0 : sat_add(edge_r, gap_r)) : left_r;
    sub       = (sym_a == sym_b) ? match_r : mis_r;
    h_raw     = max2(max2(sat_add(diag, sub), sat_add(up, gap_r)), sat_add(left, gap_r));
    h         = (mode_r && h_raw[SCORE_W-1]) ? '0 : h_raw;
    row_we    = (state == INIT) || (state == COMPUTE);
    row_wdata = (state == INIT) ? (mode_r ? '0 : init_val) : h;
  end

  always_ff @(posedge clk) begin
    if (seq_valid && seq_ready) begin
      if (!seq_sel && seq_addr < MAX_N_L) mem_a[seq_addr[AW_A-1:0]] <= seq_sym;
      if (seq_sel && seq_addr < MAX_M_L)  mem_b[seq_addr[AW_B-1:0]] <= seq_sym;
    end
    if (row_we) row[j_cnt[RW-1:0]] <= row_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_r      <= '0;
      m_r      <= '0;
      i_cnt    <= '0;
      j_cnt    <= '0;
      match_r  <= '0;
      mis_r    <= '0;
      gap_r    <= '0;
      mode_r   <= 1'b0;
      init_val <= '0;
      edge_r   <= '0;
      diag_r   <= '0;
      left_r   <= '0;
      best_r   <= '0;
      solution <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && start && cfg_bad;
      case (state)
        IDLE: begin
          if (start && !cfg_bad) begin
            n_r      <= n_len;
            m_r      <= m_len;
            match_r  <= match_score;
            mis_r    <= mismatch_penalty;
            gap_r    <= gap_penalty;
            mode_r   <= mode;
            i_cnt    <= LEN_W'(1);
            j_cnt    <= '0;
            init_val <= '0;
          end
        end
        INIT: begin
          // Saturating accumulation equals the clamped product j*gap since gap has a fixed sign.
          init_val <= sat_add(init_val, gap_r);
          edge_r   <= '0;
          best_r   <= '0;
          j_cnt    <= (j_cnt == m_r) ? LEN_W'(1) : j_cnt + 1'b1;
        end
        COMPUTE: begin
          diag_r <= up;
          left_r <= h;
          best_r <= max2(best_r, h);
          if (j_cnt == m_r) begin
            j_cnt  <= LEN_W'(1);
            i_cnt  <= i_cnt + 1'b1;
            edge_r <= sat_add(edge_r, gap_r);
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
          if (last_cell) solution <= mode_r ? max2(best_r, h) : h;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alignment_engine.sv
// tb/tb_alignment_engine.sv - self-checking bench for alignment_engine
// Table vectors, corner-case sequences and random runs against a full-matrix DP model.
module tb_alignment_engine;
  logic              clk = 1'b0;
  logic              reset;
  logic              seq_valid, seq_ready, seq_sel;
  logic [6:0]        seq_addr;
  logic [1:0]        seq_sym;
  logic [6:0]        n_len, m_len;
  logic [15:0]       match_score, mismatch_penalty, gap_penalty;
  logic              mode, start, busy, cfg_err, sol_valid, sol_ready;
  logic [15:0]       solution;

  alignment_engine dut (
    .clk(clk), .reset(reset), .seq_valid(seq_valid), .seq_ready(seq_ready),
    .seq_sel(seq_sel), .seq_addr(seq_addr), .seq_sym(seq_sym),
    .n_len(n_len), .m_len(m_len), .match_score(match_score),
    .mismatch_penalty(mismatch_penalty), .gap_penalty(gap_penalty), .mode(mode),
    .start(start), .busy(busy), .cfg_err(cfg_err), .sol_valid(sol_valid),
    .sol_ready(sol_ready), .solution(solution)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ta [64];
  int tb_ [64];

  typedef struct {
    int n; int m; logic [15:0] a; logic [15:0] b;
    int mt; int mm; int gp; bit md; int exp;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int ref_score(input int n, input int m, input int mt, input int mm,
                                   input int gp, input bit md);
    int h [0:64][0:64];
    int best, s, v;
    best = 0;
    for (int i = 0; i <= n; i++) h[i][0] = md ? 0 : clamp(i * gp);
    for (int j = 0; j <= m; j++) h[0][j] = md ? 0 : clamp(j * gp);
    for (int i = 1; i <= n; i++)
      for (int j = 1; j <= m; j++) begin
        s = (ta[i-1] == tb_[j-1]) ? mt : mm;
        v = clamp(h[i-1][j-1] + s);
        if (clamp(h[i-1][j] + gp) > v) v = clamp(h[i-1][j] + gp);
        if (clamp(h[i][j-1] + gp) > v) v = clamp(h[i][j-1] + gp);
        if (md && v < 0) v = 0;
        if (v > best) best = v;
        h[i][j] = v;
      end
    return md ? best : h[n][m];
  endfunction

  task automatic write_sym(input bit sel, input int addr, input int sym);
    seq_valid = 1'b1; seq_sel = sel; seq_addr = 7'(addr); seq_sym = 2'(sym);
    @(posedge clk); @(negedge clk);
    seq_valid = 1'b0;
  endtask

  task automatic load(input int n, input int m);
    for (int i = 0; i < n; i++) write_sym(1'b0, i, ta[i]);
    for (int j = 0; j < m; j++) write_sym(1'b1, j, tb_[j]);
  endtask

  task automatic set_cfg(input int n, input int m, input int mt, input int mm, input int gp,
                         input bit md);
    n_len = 7'(n); m_len = 7'(m); match_score = 16'(mt);
    mismatch_penalty = 16'(mm); gap_penalty = 16'(gp); mode = md;
  endtask

  task automatic start_job(input int n, input int m, input int mt, input int mm, input int gp,
                           input bit md);
    set_cfg(n, m, mt, mm, gp, md);
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    n_len = 7'($urandom); m_len = 7'($urandom); match_score = 16'($urandom);
    mismatch_penalty = 16'($urandom); gap_penalty = 16'($urandom); mode = 1'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_sol(output int lat);
    lat = 1;
    while (!sol_valid && lat < 10000) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("sol_valid_within_bound", sol_valid, 1);
  endtask

  task automatic accept(output int sol);
    sol = int'($signed(solution));
    sol_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    sol_ready = 1'b0;
    check("idle_after_accept", {busy, sol_valid}, 0);
  endtask

  task automatic run_full(input int n, input int m, input int mt, input int mm, input int gp,
                          input bit md, output int sol, output int lat);
    start_job(n, m, mt, mm, gp, md);
    wait_sol(lat);
    accept(sol);
  endtask

  initial begin
    int sol, lat, exp, held;
    int n, m, mt, mm, gp;
    bit md;
    reset = 1'b1; seq_valid = 1'b0; seq_sel = 1'b0; seq_addr = '0; seq_sym = '0;
    start = 1'b0; sol_ready = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);

    vecs[0] = '{4, 4, 16'h00E4, 16'h00E4, 1, 0, 0, 1'b0, 4};
    vecs[1] = '{4, 3, 16'h0000, 16'h0000, 2, -1, -2, 1'b0, 4};
    vecs[2] = '{7, 7, 16'h3E4F, 16'h2A4A, 1, -1, -1, 1'b1, 3};
    vecs[3] = '{2, 2, 16'h0000, 16'h0005, 1, -32768, -32768, 1'b0, -32768};

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_sol_valid", sol_valid, 0);
    check("reset_solution", solution, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", {seq_ready, busy, cfg_err, sol_valid}, 4'b1000);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].n; i++) ta[i] = int'(vecs[v].a[2*i +: 2]);
      for (int j = 0; j < vecs[v].m; j++) tb_[j] = int'(vecs[v].b[2*j +: 2]);
      load(vecs[v].n, vecs[v].m);
      if (v == 0) begin
        write_sym(1'b0, 64, 3);
        write_sym(1'b1, 64, 3);
      end
      run_full(vecs[v].n, vecs[v].m, vecs[v].mt, vecs[v].mm, vecs[v].gp, vecs[v].md, sol, lat);
      check($sformatf("vec%0d_solution", v), sol, vecs[v].exp);
      check($sformatf("vec%0d_latency", v), lat, vecs[v].m + 2 + vecs[v].n * vecs[v].m);
    end

    // Held output: solution stable, start ignored, then release.
    for (int i = 0; i < 3; i++) ta[i] = int'($urandom_range(0, 3));
    for (int j = 0; j < 5; j++) tb_[j] = int'($urandom_range(0, 3));
    load(3, 5);
    exp = ref_score(3, 5, 3, -2, -1, 1'b0);
    start_job(3, 5, 3, -2, -1, 1'b0);
    wait_sol(lat);
    check("hold_latency", lat, 22);
    held = 0;
    for (int k = 0; k < 10; k++) begin
      set_cfg(2, 2, 1, 0, 0, 1'b0);
      start = 1'b1;
      if (sol_valid !== 1'b1 || int'($signed(solution)) != exp || cfg_err !== 1'b0) held++;
      @(posedge clk); @(negedge clk);
    end
    check("hold_stable_cycles_bad", held, 0);
    check("hold_solution", int'($signed(solution)), exp);
    sol_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; sol_ready = 1'b0;
    check("release_to_idle", {busy, sol_valid}, 0);
    @(posedge clk); @(negedge clk);
    check("start_during_out_ignored", {busy, cfg_err}, 0);

    // Rejected configurations.
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: set_cfg(0, 4, 1, 0, 0, 1'b0);
        1: set_cfg(4, 65, 1, 0, 0, 1'b0);
        default: set_cfg(65, 4, 1, 0, 0, 1'b0);
      endcase
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      check($sformatf("cfg_err_pulse%0d", k), {cfg_err, busy, sol_valid}, 3'b100);
      @(posedge clk); @(negedge clk);
      check($sformatf("cfg_err_clear%0d", k), {cfg_err, busy, sol_valid}, 3'b000);
    end

    // Reset mid-COMPUTE, then rerun the AAAA/AAA case.
    for (int i = 0; i < 4; i++) ta[i] = 0;
    for (int j = 0; j < 3; j++) tb_[j] = 0;
    load(4, 3);
    start_job(4, 3, 2, -1, -2, 1'b0);
    repeat (6) begin @(posedge clk); @(negedge clk); end
    check("busy_mid_compute", busy, 1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {busy, sol_valid}, 0);
    check("async_reset_solution", solution, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_idle", {seq_ready, busy, sol_valid}, 3'b100);
    load(4, 3);
    run_full(4, 3, 2, -1, -2, 1'b0, sol, lat);
    check("rerun_solution", sol, 4);
    check("rerun_latency", lat, 17);

    // Random runs against the DP model; run 0 is the maximum size.
    for (int r = 0; r < 24; r++) begin
      n = (r == 0) ? 64 : int'($urandom_range(1, 12));
      m = (r == 0) ? 64 : int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) ta[i] = int'($urandom_range(0, 3));
      for (int j = 0; j < m; j++) tb_[j] = int'($urandom_range(0, 3));
      if (r % 4 == 3) begin
        mt = int'($urandom_range(0, 30000));
        mm = -int'($urandom_range(0, 32768));
        gp = -int'($urandom_range(0, 32768));
      end else begin
        mt = int'($urandom_range(0, 5));
        mm = -int'($urandom_range(0, 5));
        gp = -int'($urandom_range(0, 4));
      end
      md = 1'($urandom);
      load(n, m);
      exp = ref_score(n, m, mt, mm, gp, md);
      run_full(n, m, mt, mm, gp, md, sol, lat);
      check($sformatf("rand%0d_solution n=%0d m=%0d mode=%0d", r, n, m, md), sol, exp);
      check($sformatf("rand%0d_latency", r), lat, m + 2 + n * m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
